// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
// Rate-1/2 convolutional encoder (K = 3, 5 or 7) for the Viterbi codec.
// Takes one info bit per handshake and emits one 2-bit symbol {c0,c1} for each bit.
// After the last info bit it appends K-1 zero tail bits, so the trellis ends in state 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | between frames; the first accepted bit latches the constraint length
// ENC   | encoding info bits; an accept with i_last moves to FLUSH
// FLUSH | pushing zero tail bits, one per output advance
// DRAIN | last tail symbol is loaded; waiting for downstream to take it
module conv_encoder_tx #(
    parameter logic [2:0] G3_0 = 3'o7,
    parameter logic [2:0] G3_1 = 3'o5,
    parameter logic [4:0] G5_0 = 5'o23,
    parameter logic [4:0] G5_1 = 5'o35,
    parameter logic [6:0] G7_0 = 7'o171,
    parameter logic [6:0] G7_1 = 7'o133
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] i_constr_len,
    input  logic       i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [1:0] o_code,
    output logic       o_valid,
    input  logic       i_out_ready,
    output logic       o_last,
    output logic       o_done
);

    // Constraint-length select codes; any other value falls back to K=3.
    localparam logic [1:0] CONSTR_LEN_3 = 2'd0;
    localparam logic [1:0] CONSTR_LEN_5 = 2'd1;
    localparam logic [1:0] CONSTR_LEN_7 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state;
    logic [5:0] sr;
    logic [2:0] tail_cnt;
    logic [1:0] k_r;

    logic       adv;
    logic       accept;
    logic [1:0] k_sel;
    logic       enc_bit;
    logic [1:0] code_next;
    logic [5:0] sr_next;

    // Maps the raw select to one of the three supported lengths.
    function automatic logic [1:0] norm_len(input logic [1:0] sel);
        logic [1:0] r;
        case (sel)
            CONSTR_LEN_5: r = CONSTR_LEN_5;
            CONSTR_LEN_7: r = CONSTR_LEN_7;
            default:      r = CONSTR_LEN_3;
        endcase
        return r;
    endfunction

    // Number of tail bits (K-1) for a normalized length.
    function automatic logic [2:0] tail_len(input logic [1:0] k);
        logic [2:0] r;
        case (k)
            CONSTR_LEN_5: r = 3'd4;
            CONSTR_LEN_7: r = 3'd6;
            default:      r = 3'd2;
        endcase
        return r;
    endfunction

    // The window has the current bit in its MSB and the oldest history bit in its LSB.
    // Each generator is zero-extended to 7 bits so one XOR-reduce serves every K.
    function automatic logic [1:0] encode(input logic b, input logic [5:0] s,
                                          input logic [1:0] k);
        logic [6:0] w;
        logic [6:0] g0;
        logic [6:0] g1;
        case (k)
            CONSTR_LEN_5: begin
                w  = {2'b00, b, s[0], s[1], s[2], s[3]};
                g0 = {2'b00, G5_0};
                g1 = {2'b00, G5_1};
            end
            CONSTR_LEN_7: begin
                w  = {b, s[0], s[1], s[2], s[3], s[4], s[5]};
                g0 = G7_0;
                g1 = G7_1;
            end
            default: begin
                w  = {4'b0000, b, s[0], s[1]};
                g0 = {4'b0000, G3_0};
                g1 = {4'b0000, G3_1};
            end
        endcase
        return {^(w & g0), ^(w & g1)};
    endfunction

    // Shifts the new bit into sr[0]. The mask keeps bits above K-2 at zero.
    function automatic logic [5:0] shift_in(input logic b, input logic [5:0] s,
                                            input logic [1:0] k);
        logic [5:0] mask;
        case (k)
            CONSTR_LEN_5: mask = 6'b001111;
            CONSTR_LEN_7: mask = 6'b111111;
            default:      mask = 6'b000011;
        endcase
        return {s[4:0], b} & mask;
    endfunction

    // Handshake qualifiers and the next symbol.
    // In IDLE the incoming select is used directly, because it is latched on that same accept.
    always_comb begin
        adv       = !o_valid || i_out_ready;
        o_ready   = rst && en && adv && ((state == IDLE) || (state == ENC));
        accept    = o_ready && i_valid;
        k_sel     = (state == IDLE) ? norm_len(i_constr_len) : k_r;
        enc_bit   = (state == FLUSH) ? 1'b0 : i_data;
        code_next = encode(enc_bit, sr, k_sel);
        sr_next   = shift_in(enc_bit, sr, k_sel);
    end

    // Frame sequencing, shift register and registered output stage. Nothing moves while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            tail_cnt <= '0;
            k_r      <= CONSTR_LEN_3;
            o_code   <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_done   <= 1'b0;
        end else if (en) begin
            o_done <= 1'b0;
            case (state)
                IDLE, ENC: begin
                    if (accept) begin
                        o_code  <= code_next;
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        sr      <= sr_next;
                        if (state == IDLE) begin
                            k_r <= k_sel;
                        end
                        if (i_last) begin
                            state    <= FLUSH;
                            tail_cnt <= tail_len(k_sel);
                        end else begin
                            state <= ENC;
                        end
                    end else if (adv) begin
                        o_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (adv) begin
                        o_code   <= code_next;
                        o_valid  <= 1'b1;
                        sr       <= sr_next;
                        tail_cnt <= tail_cnt - 3'd1;
                        if (tail_cnt == 3'd1) begin
                            o_last <= 1'b1;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (o_valid && i_out_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        o_done  <= 1'b1;
                        sr      <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx
// Directed bench for conv_encoder_tx. Expected symbols are worked out by hand from the generators.
module tb_conv_encoder_tx;

    localparam logic [1:0] L3 = 2'd0;
    localparam logic [1:0] L5 = 2'd1;
    localparam logic [1:0] L7 = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] i_constr_len;
    logic       i_data;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [1:0] o_code;
    logic       o_valid;
    logic       i_out_ready;
    logic       o_last;
    logic       o_done;

    int checks   = 0;
    int failures = 0;

    // Monitor state
    int         cyc = 0;
    int         last_acc_cyc = -100;
    int         done_cyc = -100;
    int         done_cnt = 0;
    int         stall_bad = 0;
    int         ready_bad = 0;
    logic       stall_prev = 1'b0;
    logic [1:0] code_prev = 2'b00;
    logic       last_prev = 1'b0;
    logic [1:0] cap_code[$];
    logic       cap_last[$];
    logic [1:0] exp_q[$];

    // Back-pressure driver state
    logic bp_on = 1'b0;
    logic ready_level = 1'b1;
    int   ph = 0;

    conv_encoder_tx dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .i_constr_len(i_constr_len),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_code      (o_code),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_last      (o_last),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Drives i_out_ready. When back-pressure is on it follows the repeating pattern 1,0,0,1.
    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                i_out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                i_out_ready = ready_level;
            end
        end
    end

    // Mid-cycle monitor: captures accepted symbols, checks that stalled symbols hold, and records o_done.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                if (!(o_valid === 1'b1 && o_code === code_prev && o_last === last_prev))
                    stall_bad++;
            end
            if (o_valid && !i_out_ready && o_ready) ready_bad++;
            stall_prev = o_valid && (!i_out_ready || !en);
            code_prev  = o_code;
            last_prev  = o_last;
            if (o_valid && i_out_ready && en) begin
                cap_code.push_back(o_code);
                cap_last.push_back(o_last);
                if (o_last) last_acc_cyc = cyc;
            end
            if (o_done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input logic b, input logic last);
        logic acc;
        acc     = 1'b0;
        i_data  = b;
        i_last  = last;
        i_valid = 1'b1;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = o_ready;
            tick();
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
    endtask

    // Bit i of 'bits' is sent i-th; the final bit carries i_last.
    task automatic run_frame(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) push_bit(bits[i], (i == n - 1));
    endtask

    task automatic wait_done(input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            @(negedge clk);
            #1;
            if (o_done === 1'b1) found = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
        chk({tag, "_done_latency"}, done_cyc - last_acc_cyc, 32'd1);
        @(negedge clk);
        #1;
        chk({tag, "_done_width"}, {31'd0, o_done}, 32'd0);
        tick();
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nsym"}, cap_code.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_code.size()) begin
                chk($sformatf("%s_sym%0d", tag, i), {30'd0, cap_code[i]}, {30'd0, exp_q[i]});
                chk($sformatf("%s_last%0d", tag, i), {31'd0, cap_last[i]},
                    {31'd0, (i == exp_q.size() - 1)});
            end
        end
        cap_code.delete();
        cap_last.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0] snap_code;
        logic       snap_valid;
        int         done_snap;

        rst          = 1'b0;
        en           = 1'b1;
        i_constr_len = L3;
        i_data       = 1'b0;
        i_valid      = 1'b0;
        i_last       = 1'b0;

        // Outputs while reset is held
        #2;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_code",  {30'd0, o_code},  32'd0);
        chk("rst_last",  {31'd0, o_last},  32'd0);
        chk("rst_done",  {31'd0, o_done},  32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("idle_ready", {31'd0, o_ready}, 32'd1);
        tick();

        // Test 1: K=3, bits 1,0,1,1
        run_frame(8'b0000_1101, 4);
        @(negedge clk);
        chk("flush_ready_low", {31'd0, o_ready}, 32'd0);
        tick();
        wait_done("t1");
        exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        check_frame("t1");

        // Test 2: K=5 impulse; the generator bits come out MSB-first as {G5_0,G5_1} pairs
        i_constr_len = L5;
        run_frame(8'b0000_0001, 1);
        wait_done("t2");
        exp_q = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b11};
        check_frame("t2");

        // Test 3: test 1 again with back-pressure
        i_constr_len = L3;
        ph    = 0;
        bp_on = 1'b1;
        run_frame(8'b0000_1101, 4);
        wait_done("t3");
        bp_on = 1'b0;
        tick();
        exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        check_frame("t3");

        // Test 4: en low for 3 cycles mid-frame while a bit is offered
        push_bit(1'b1, 1'b0);
        push_bit(1'b0, 1'b0);
        snap_code  = o_code;
        snap_valid = o_valid;
        en      = 1'b0;
        i_valid = 1'b1;
        i_data  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t4_ready_off%0d", c), {31'd0, o_ready}, 32'd0);
            chk($sformatf("t4_code_hold%0d", c), {30'd0, o_code}, {30'd0, snap_code});
            chk($sformatf("t4_valid_hold%0d", c), {31'd0, o_valid}, {31'd0, snap_valid});
            tick();
        end
        i_valid = 1'b0;
        en      = 1'b1;
        push_bit(1'b1, 1'b0);
        push_bit(1'b1, 1'b1);
        wait_done("t4");
        exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        check_frame("t4");

        // Test 5: asynchronous reset during FLUSH
        run_frame(8'b0000_0101, 3);
        rst = 1'b0;
        #1;
        chk("t5_valid", {31'd0, o_valid}, 32'd0);
        chk("t5_code",  {30'd0, o_code},  32'd0);
        chk("t5_last",  {31'd0, o_last},  32'd0);
        chk("t5_done",  {31'd0, o_done},  32'd0);
        chk("t5_ready", {31'd0, o_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        cap_code.delete();
        cap_last.delete();
        done_snap = done_cnt;
        for (int c = 0; c < 6; c++) tick();
        chk("t5_no_done", done_cnt, done_snap);
        chk("t5_no_sym", cap_code.size(), 32'd0);
        run_frame(8'b0000_0001, 1);
        wait_done("t5");
        exp_q = '{2'b11, 2'b10, 2'b11};
        check_frame("t5");

        // Test 6: select changed to K=7 mid-frame; the change takes effect on the next frame
        i_constr_len = L3;
        push_bit(1'b1, 1'b0);
        i_constr_len = L7;
        push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b1);
        wait_done("t6a");
        exp_q = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
        check_frame("t6a");
        run_frame(8'b0000_0001, 1);
        wait_done("t6b");
        exp_q = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
        check_frame("t6b");

        chk("stall_hold", stall_bad, 32'd0);
        chk("stall_ready_low", ready_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
